seq_mag_comparator: RTL and testbench
=====================================

Name: seq_mag_comparator

Overview:
Parametrised sequential magnitude comparator; successor to the 4-bit equality comparator. Compares two WIDTH-bit unsigned operands CHUNK bits per cycle, MSB chunk first, and exits early on the first differing chunk. Reports one-hot greater/equal/less flags behind a start/busy/done handshake. Used where wide operand compares must not sit in a single combinational path.

Parameters:
WIDTH, 8, operand width in bits (>=1)
CHUNK, 2, bits compared per cycle; WIDTH % CHUNK must be 0, else elaboration error
NUM_CHUNKS, WIDTH/CHUNK, derived localparam, not overridable

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, unsigned; captured on accepted start
b  input  WIDTH  operand B, unsigned; captured on accepted start
busy  output  1  high while in COMPARE
done  output  1  one-cycle pulse when result flags update
a_gt_b  output  1  result: A > B
a_eq_b  output  1  result: A == B
a_lt_b  output  1  result: A < B

Behaviour:
- One clock (clk); rst_n is asynchronous, active-low. While rst_n is low: state=IDLE, busy=0, done=0, all flags=0, shadow operands=0, chunk index=0.
- States: IDLE, COMPARE.
- IDLE: start=1 at edge t -> capture a,b into shadow regs; idx=NUM_CHUNKS-1; clear all three flags; state=COMPARE. start=0 -> stay IDLE.
- COMPARE, each edge: compare shadow chunk idx, bits [idx*CHUNK+CHUNK-1 : idx*CHUNK].
  - Chunk A > B -> a_gt_b=1, done=1, state=IDLE.
  - Chunk A < B -> a_lt_b=1, done=1, state=IDLE.
  - Chunks equal and idx==0 -> a_eq_b=1, done=1, state=IDLE.
  - Chunks equal and idx>0 -> idx=idx-1, stay in COMPARE.
- Latency: when m chunks are examined (1..NUM_CHUNKS), done is registered high at edge t+m. Minimum 1 cycle, maximum NUM_CHUNKS cycles.
- busy is high from edge t to edge t+m, i.e. exactly m cycles.
- done is high for exactly one cycle; cleared at the next edge unless that edge also completes a new compare.
- Flags:
  - Exactly one flag is high after any completion.
  - All flags are 0 between an accepted start and its done.
  - Flags hold their value after done until the next accepted start.
- start while busy: ignored. No queueing, no effect on the result.
- a/b changes after start is accepted: ignored; the compare uses the shadow values.
- start high in the cycle done is high: state is already IDLE, so the start is accepted (back-to-back, no bubble).
- rst_n asserted mid-compare: immediate abort, no done pulse, all outputs 0.
- CHUNK==WIDTH: single-cycle compare; busy high 1 cycle.
- All arithmetic is unsigned. idx width is clog2(NUM_CHUNKS), minimum 1 bit.

Decomposition:
- Shared include cmp_defs.vh: state encodings (S_IDLE=1'b0, S_COMPARE=1'b1) and the result-flag bit positions (GT/EQ/LT).
- One sub-module: chunk_cmp, a combinational CHUNK-bit unsigned magnitude compare with outputs gt/eq/lt. It generalises the previous equality comparator and is instantiated once with the shared parameter CHUNK.
- FSM, shadow registers and chunk mux live in the top module.

Test Plan:
1. rst_n=0 with start=1, a=8'hFF -> busy=0, done=0, all flags 0 throughout reset. Release -> remains IDLE until start.
2. WIDTH=8, CHUNK=2; a=8'hC3, b=8'h43, start pulse at edge t -> MSB chunk 11>01. At edge t+1: a_gt_b=1, done=1 for one cycle; busy was high 1 cycle.
3. a=b=8'hA5 -> all 4 chunks equal. At edge t+4: a_eq_b=1, done=1; busy high 4 cycles; flags are 0 during cycles t..t+3.
4. a=8'h34, b=8'h36 -> decided at chunk 0 (00 vs 10). At edge t+4: a_lt_b=1. Then change a=8'hFF and hold start=0 -> flags unchanged.
5. Start with a=8'h10, b=8'h20; during busy, change to a=8'hFF and pulse start -> result a_lt_b at t+2, no second done. Re-assert start in the done cycle with a=b=8'h00 -> accepted; a_eq_b after 4 more cycles.
6. WIDTH=8, CHUNK=2; start a=b=8'h5A, pull rst_n low at t+2 -> outputs 0 immediately, no done. Repeat scenario 2 with WIDTH=CHUNK=4, a=4'h9, b=4'h3 -> a_gt_b and done at t+1.

Source files
------------

// File: rtl/seq_mag_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator:
// FSM state encodings and the bit positions of the result flags.
package seq_mag_comparator_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COMPARE = 1'b1
  } state_t;

  localparam int FLAG_GT = 2;
  localparam int FLAG_EQ = 1;
  localparam int FLAG_LT = 0;

endpackage

// File: rtl/seq_mag_comparator_chunk_cmp.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
// Exactly one of gt/eq/lt is high for any input pair.
module chunk_cmp #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Sequential WIDTH-bit unsigned magnitude comparator: walks the operands
// CHUNK bits per cycle from the MSB end and stops at the first differing chunk.
module seq_mag_comparator
  import seq_mag_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("seq_mag_comparator: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       flags_q, flags_d;
  logic             done_q, done_d;

  // Shadow operands viewed as an array of chunks so the mux is a plain index
  logic [NUM_CHUNKS-1:0][CHUNK-1:0] a_chunks, b_chunks;
  logic                             chunk_gt, chunk_eq, chunk_lt;

  assign a_chunks = a_q;
  assign b_chunks = b_q;

  chunk_cmp #(
    .CHUNK(CHUNK)
  ) u_chunk_cmp (
    .a  (a_chunks[idx_q]),
    .b  (b_chunks[idx_q]),
    .gt (chunk_gt),
    .eq (chunk_eq),
    .lt (chunk_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDX_W'(NUM_CHUNKS - 1);
          flags_d = '0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        // Start is deliberately not looked at here: requests while busy are dropped
        if (chunk_gt) begin
          flags_d          = '0;
          flags_d[FLAG_GT] = 1'b1;
          done_d           = 1'b1;
          state_d          = S_IDLE;
        end else if (chunk_lt) begin
          flags_d          = '0;
          flags_d[FLAG_LT] = 1'b1;
          done_d           = 1'b1;
          state_d          = S_IDLE;
        end else if (chunk_eq && idx_q == '0) begin
          flags_d          = '0;
          flags_d[FLAG_EQ] = 1'b1;
          done_d           = 1'b1;
          state_d          = S_IDLE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_COMPARE);
  assign done   = done_q;
  assign a_gt_b = flags_q[FLAG_GT];
  assign a_eq_b = flags_q[FLAG_EQ];
  assign a_lt_b = flags_q[FLAG_LT];

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Self-checking bench: an 8-bit/2-bit instance and a 4-bit/4-bit instance
// checked cycle by cycle against a chunk-walk reference model.
module tb_seq_mag_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy8, done8, gt8, eq8, lt8;
  logic       busy4, done4, gt4, eq4, lt4;
  logic       use4 = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .a_gt_b(gt8), .a_eq_b(eq8), .a_lt_b(lt8)
  );

  seq_mag_comparator #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .a_gt_b(gt4), .a_eq_b(eq4), .a_lt_b(lt4)
  );

  // Observed status of the selected instance: {busy, done, gt, eq, lt}
  logic [4:0] obs;
  assign obs = use4 ? {busy4, done4, gt4, eq4, lt4} : {busy8, done8, gt8, eq8, lt8};

  // Number of chunks inspected before the MSB-first walk reaches a decision
  function automatic int model_latency(input int unsigned x, input int unsigned y,
                                       input int w, input int c);
    int          n    = w / c;
    int unsigned mask = (32'd1 << c) - 32'd1;
    for (int i = n - 1; i >= 0; i--) begin
      if (((x >> (i * c)) & mask) != ((y >> (i * c)) & mask)) return n - i;
    end
    return n;
  endfunction

  function automatic logic [2:0] model_flags(input int unsigned x, input int unsigned y);
    return {x > y, x == y, x < y};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input logic [7:0] x, input logic [7:0] y);
    if (use4) begin
      start4 = s; a4 = x[3:0]; b4 = y[3:0];
    end else begin
      start8 = s; a8 = x; b8 = y;
    end
  endtask

  task automatic check_output(input string tag, input logic [4:0] expected);
    checks++;
    assert (obs === expected) else begin
      errors++;
      $error("FAIL %s: observed busy,done,gt,eq,lt=%b expected=%b", tag, obs, expected);
    end
  endtask

  // One full compare on the selected instance, optionally followed by a hold check
  task automatic run_compare(input string tag, input logic [7:0] x, input logic [7:0] y,
                             input bit hold);
    int         w  = use4 ? 4 : 8;
    int         c  = use4 ? 4 : 2;
    int         m  = model_latency(use4 ? int'(x[3:0]) : int'(x), use4 ? int'(y[3:0]) : int'(y), w, c);
    logic [2:0] ef = model_flags(use4 ? int'(x[3:0]) : int'(x), use4 ? int'(y[3:0]) : int'(y));
    apply_stimulus(1'b1, x, y);
    tick;
    apply_stimulus(1'b0, x, y);
    check_output({tag, "_accept"}, 5'b10000);
    for (int k = 1; k < m; k++) begin
      tick;
      check_output({tag, "_busy"}, 5'b10000);
    end
    tick;
    check_output({tag, "_done"}, {2'b01, ef});
    if (hold) begin
      tick;
      check_output({tag, "_hold"}, {2'b00, ef});
    end
  endtask

  initial begin
    // Reset with start high and operands non-zero: nothing may move
    rst_n = 1'b0;
    apply_stimulus(1'b1, 8'hFF, 8'h00);
    use4 = 1'b1;
    apply_stimulus(1'b1, 8'h0F, 8'h00);
    use4 = 1'b0;
    #1;
    check_output("reset_async", 5'b00000);
    for (int k = 0; k < 3; k++) begin
      tick;
      check_output("reset_hold", 5'b00000);
    end
    use4 = 1'b1;
    check_output("reset_dut4", 5'b00000);
    apply_stimulus(1'b0, 8'h00, 8'h00);
    use4 = 1'b0;
    apply_stimulus(1'b0, 8'hFF, 8'h00);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      check_output("idle_after_reset", 5'b00000);
    end

    // Directed cases: MSB decision, full-length equal, LSB decision
    run_compare("gt_msb", 8'hC3, 8'h43, 1'b1);
    run_compare("eq_all", 8'hA5, 8'hA5, 1'b1);
    run_compare("lt_lsb", 8'h34, 8'h36, 1'b0);
    apply_stimulus(1'b0, 8'hFF, 8'h36);
    for (int k = 0; k < 3; k++) begin
      tick;
      check_output("flags_hold", 5'b00001);
    end

    // Start during busy is dropped; start in the done cycle is taken
    apply_stimulus(1'b1, 8'h10, 8'h20);
    tick;
    check_output("ign_accept", 5'b10000);
    apply_stimulus(1'b1, 8'hFF, 8'h20);
    tick;
    check_output("ign_busy", 5'b10000);
    apply_stimulus(1'b0, 8'hFF, 8'h20);
    tick;
    check_output("ign_done", 5'b01001);
    apply_stimulus(1'b1, 8'h00, 8'h00);
    tick;
    check_output("b2b_accept", 5'b10000);
    apply_stimulus(1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick;
      check_output("b2b_busy", 5'b10000);
    end
    tick;
    check_output("b2b_done", 5'b01010);
    tick;
    check_output("b2b_hold", 5'b00010);

    // Reset mid-compare aborts without a done pulse
    apply_stimulus(1'b1, 8'h5A, 8'h5A);
    tick;
    apply_stimulus(1'b0, 8'h5A, 8'h5A);
    tick;
    tick;
    check_output("abort_pre", 5'b10000);
    rst_n = 1'b0;
    #1;
    check_output("abort_async", 5'b00000);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check_output("abort_no_done", 5'b00000);
    end

    // Single-chunk instance, including a start held across its done cycle
    use4 = 1'b1;
    run_compare("w4_gt", 8'h09, 8'h03, 1'b1);
    apply_stimulus(1'b1, 8'h09, 8'h03);
    tick;
    check_output("w4_b2b_accept", 5'b10000);
    apply_stimulus(1'b1, 8'h03, 8'h09);
    tick;
    check_output("w4_b2b_done1", 5'b01100);
    tick;
    check_output("w4_b2b_accept2", 5'b10000);
    apply_stimulus(1'b0, 8'h03, 8'h09);
    tick;
    check_output("w4_b2b_done2", 5'b01001);
    tick;
    check_output("w4_b2b_hold", 5'b00001);

    // Random pairs, biased towards long equal prefixes
    for (int n = 0; n < 24; n++) begin
      logic [7:0] x, y;
      int         mode;
      x    = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 3);
      if (mode == 0)      y = x;
      else if (mode == 1) y = 8'($urandom_range(0, 255));
      else                y = x ^ (8'd1 << $urandom_range(0, 7));
      use4 = (n % 4 == 3);
      run_compare(use4 ? "rand_w4" : "rand_w8", x, y, (n % 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
